// File: rtl/systolic_array_pkg.sv
// Shared definitions for the systolic array: default geometry and the
// row sequencer state encoding.
`timescale 1ns/1ps
package systolic_array_pkg;

  localparam int N  = 4;
  localparam int DW = 16;

  typedef enum logic [2:0] {
    IDLE,
    WLOAD,
    WAIT_SPACE,
    ILOAD,
    GAP,
    DRAIN,
    DONE
  } seq_state_e;

endpackage

// File: rtl/systolic_array_row_sequencer.sv
// Feeds weight rows and input/partial-sum rows into the systolic array, then waits for drain.
// Optional: define SA_SEQ_PERF_CNT_EN to add the 16-bit stall_cnt output.
`timescale 1ns/1ps
module systolic_array_row_sequencer #(
  parameter int N     = systolic_array_pkg::N,
  parameter int DW    = systolic_array_pkg::DW,
  parameter int DLY_W = 4
) (
  input  logic                  clk,
  input  logic                  RST,
  input  logic                  start,
  input  logic                  load_weights,
  input  logic [DLY_W-1:0]      row_delay,
  input  logic                  src_valid,
  output logic                  src_ready,
  input  logic [N*DW-1:0]       src_data,
  input  logic [N*DW-1:0]       src_partial,
  output logic                  weight_en,
  output logic                  input_en,
  output logic                  partial_en,
  output logic [$clog2(N)-1:0]  row_in_en,
  output logic [$clog2(N)-1:0]  row_ps_en,
  output logic [N*DW-1:0]       array_in,
  output logic [N*DW-1:0]       array_in_partials,
  input  logic                  fifo_has_space,
  input  logic                  drained,
  input  logic                  out_en,
  output logic                  busy,
  output logic                  done
`ifdef SA_SEQ_PERF_CNT_EN
  ,
  output logic [15:0]           stall_cnt
`endif
);
  import systolic_array_pkg::*;

  localparam int RW  = $clog2(N);
  localparam int OCW = $clog2(N + 1);
  localparam logic [RW-1:0]  LAST_ROW = RW'(N - 1);
  localparam logic [OCW-1:0] OUT_FULL = OCW'(N);

  seq_state_e       state, state_nxt;
  logic [RW-1:0]    row_cnt;
  logic [DLY_W-1:0] delay_q;
  logic [DLY_W-1:0] gap_cnt;
  logic [OCW-1:0]   out_cnt;
  logic             start_acc;
  logic             accept;
  logic             last_row;

  assign start_acc = start && (state == IDLE);
  assign accept    = src_valid && src_ready;
  assign last_row  = (row_cnt == LAST_ROW);

  // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (RST) state <= IDLE;
    else     state <= state_nxt;
  end

  // NOTE: the default at the top of each always_comb keeps every path assigned, so no latch is inferred.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:       if (start) state_nxt = load_weights ? WLOAD : WAIT_SPACE;
      WLOAD:      if (accept && last_row) state_nxt = WAIT_SPACE;
      WAIT_SPACE: if (fifo_has_space) state_nxt = ILOAD;
      ILOAD: begin
        if (accept) begin
          if (last_row)              state_nxt = DRAIN;
          else if (delay_q != '0)    state_nxt = GAP;
        end
      end
      GAP:        if (gap_cnt == DLY_W'(1)) state_nxt = ILOAD;
      DRAIN:      if ((out_cnt == OUT_FULL) && drained) state_nxt = DONE;
      DONE:       state_nxt = IDLE;
      default:    state_nxt = IDLE;
    endcase
  end

  // Held low while RST is high so the block is quiet even before the reset edge.
  always_comb begin
    src_ready = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    if (!RST) begin
      src_ready = (state == WLOAD) || (state == ILOAD);
      busy      = (state != IDLE);
      done      = (state == DONE);
    end
  end

  always_ff @(posedge clk) begin
    if (RST) begin
      row_cnt <= '0;
      delay_q <= '0;
      gap_cnt <= '0;
      out_cnt <= '0;
    end else begin
      if (start_acc) begin
        delay_q <= row_delay;
        row_cnt <= '0;
      end else if (accept) begin
        row_cnt <= last_row ? '0 : row_cnt + 1'b1;
      end

      if (start_acc)
        out_cnt <= '0;
      else if ((state != IDLE) && out_en && (out_cnt != OUT_FULL))
        out_cnt <= out_cnt + 1'b1;

      if ((state == ILOAD) && accept) gap_cnt <= delay_q;
      else if (state == GAP)          gap_cnt <= gap_cnt - 1'b1;
    end
  end

  // Array strobes are live for exactly the cycle after a row is accepted.
  always_ff @(posedge clk) begin
    weight_en         <= 1'b0;
    input_en          <= 1'b0;
    partial_en        <= 1'b0;
    row_in_en         <= '0;
    row_ps_en         <= '0;
    array_in          <= '0;
    array_in_partials <= '0;
    if (!RST && accept) begin
      if (state == WLOAD) begin
        weight_en <= 1'b1;
        row_in_en <= row_cnt;
        array_in  <= src_data;
      end else begin
        input_en          <= 1'b1;
        partial_en        <= 1'b1;
        row_in_en         <= row_cnt;
        row_ps_en         <= row_cnt;
        array_in          <= src_data;
        array_in_partials <= src_partial;
      end
    end
  end

`ifdef SA_SEQ_PERF_CNT_EN
  logic stall_cycle;
  assign stall_cycle = (state == WAIT_SPACE) ||
                       (((state == WLOAD) || (state == ILOAD)) && !src_valid);

  always_ff @(posedge clk) begin
    if (RST || start_acc)
      stall_cnt <= '0;
    else if (stall_cycle && (stall_cnt != 16'hFFFF))
      stall_cnt <= stall_cnt + 16'd1;
  end
`endif

endmodule

// File: tb/tb_systolic_array_row_sequencer.sv
// Randomized bench for systolic_array_row_sequencer; the expected job timeline is
// rebuilt procedurally from the sequencing rules and compared cycle by cycle.
`timescale 1ns/1ps
module tb_systolic_array_row_sequencer;

  localparam int N     = 4;
  localparam int DW    = 16;
  localparam int DLY_W = 4;
  localparam int RW    = $clog2(N);
  localparam int W     = N * DW;

  logic             tb_clk = 1'b0;
  logic             RST;
  logic             start;
  logic             load_weights;
  logic [DLY_W-1:0] row_delay;
  logic             src_valid;
  logic             src_ready;
  logic [W-1:0]     src_data;
  logic [W-1:0]     src_partial;
  logic             weight_en;
  logic             input_en;
  logic             partial_en;
  logic [RW-1:0]    row_in_en;
  logic [RW-1:0]    row_ps_en;
  logic [W-1:0]     array_in;
  logic [W-1:0]     array_in_partials;
  logic             fifo_has_space;
  logic             drained;
  logic             out_en;
  logic             busy;
  logic             done;
`ifdef SA_SEQ_PERF_CNT_EN
  logic [15:0]      stall_cnt;
`endif

  int checks = 0;
  int errors = 0;
  int exp_out;
  int exp_stall;

  always #5 tb_clk = ~tb_clk;

  systolic_array_row_sequencer #(.N(N), .DW(DW), .DLY_W(DLY_W)) dut (
    .clk               (tb_clk),
    .RST               (RST),
    .start             (start),
    .load_weights      (load_weights),
    .row_delay         (row_delay),
    .src_valid         (src_valid),
    .src_ready         (src_ready),
    .src_data          (src_data),
    .src_partial       (src_partial),
    .weight_en         (weight_en),
    .input_en          (input_en),
    .partial_en        (partial_en),
    .row_in_en         (row_in_en),
    .row_ps_en         (row_ps_en),
    .array_in          (array_in),
    .array_in_partials (array_in_partials),
    .fifo_has_space    (fifo_has_space),
    .drained           (drained),
    .out_en            (out_en),
    .busy              (busy),
    .done              (done)
`ifdef SA_SEQ_PERF_CNT_EN
    ,
    .stall_cnt         (stall_cnt)
`endif
  );

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [255:0] mk(input logic w, input logic i, input logic p,
                                      input logic [RW-1:0] ri, input logic [RW-1:0] rp,
                                      input logic [W-1:0] ai, input logic [W-1:0] ap);
    return 256'({w, i, p, ri, rp, ai, ap});
  endfunction

  function automatic logic [255:0] obs();
    return mk(weight_en, input_en, partial_en, row_in_en, row_ps_en, array_in, array_in_partials);
  endfunction

  function automatic logic [W-1:0] rand_row();
    logic [W-1:0] v = '0;
    for (int i = 0; i < (W + 31) / 32; i++) v = (v << 32) | W'($urandom);
    return v;
  endfunction

  task automatic tick();
    @(posedge tb_clk);
    #1;
  endtask

  // One job cycle; out_en pulses count from job start and saturate at N.
  task automatic job_tick();
    logic oe;
    oe = out_en;
    tick();
    if (oe && exp_out < N) exp_out++;
  endtask

  // Randomizes every input that should not matter this cycle, including start.
  task automatic noise(input int out_pct);
    out_en         = ($urandom_range(0, 99) < out_pct);
    drained        = 1'($urandom);
    start          = ($urandom_range(0, 4) == 0);
    load_weights   = 1'($urandom);
    row_delay      = DLY_W'($urandom);
    fifo_has_space = 1'($urandom);
    src_valid      = 1'($urandom);
    src_data       = rand_row();
    src_partial    = rand_row();
  endtask

  // Negative max_stall means exactly that many stall cycles per row.
  task automatic load_row(input bit is_w, input int r, input int max_stall);
    int s;
    logic [W-1:0] d, p;
    s = (max_stall < 0) ? -max_stall : int'($urandom_range(0, max_stall));
    for (int k = 0; k < s; k++) begin
      noise(20);
      src_valid = 1'b0;
      check(is_w ? "wload_stall_rdy" : "iload_stall_rdy", src_ready, 1);
      exp_stall++;
      job_tick();
      check("stall_quiet", obs(), 0);
    end
    noise(20);
    src_valid = 1'b1;
    d = src_data;
    p = src_partial;
    check(is_w ? "wload_rdy" : "iload_rdy", src_ready, 1);
    job_tick();
    if (is_w) check("weight_row", obs(), mk(1, 0, 0, RW'(r), '0, d, '0));
    else      check("input_row", obs(), mk(0, 1, 1, RW'(r), RW'(r), d, p));
  endtask

  task automatic run_job(input bit lw, input logic [DLY_W-1:0] dly, input int max_stall,
                         input int space_wait, input bit abort_gap);
    int budget;
    bit exit_now;
    noise(0);
    start        = 1'b1;
    load_weights = lw;
    row_delay    = dly;
    check("idle_busy", busy, 0);
    tick();
    exp_out   = 0;
    exp_stall = 0;
    check("start_busy", busy, 1);
    check("start_quiet", obs(), 0);

    if (lw) for (int r = 0; r < N; r++) load_row(1'b1, r, max_stall);

    for (int k = 0; k <= space_wait; k++) begin
      noise(20);
      fifo_has_space = (k == space_wait);
      check("wait_rdy", src_ready, 0);
      exp_stall++;
      job_tick();
      check("wait_quiet", obs(), 0);
    end

    for (int r = 0; r < N; r++) begin
      load_row(1'b0, r, max_stall);
      if (r < N - 1) begin
        for (int g = 0; g < int'(dly); g++) begin
          noise(20);
          if (abort_gap) begin
            RST = 1'b1;
            tick();
            check("rst_flags", {busy, done, src_ready}, 0);
            check("rst_quiet", obs(), 0);
`ifdef SA_SEQ_PERF_CNT_EN
            check("rst_stall_cnt", stall_cnt, 0);
`endif
            RST = 1'b0;
            return;
          end
          check("gap_flags", {busy, done, src_ready}, 3'b100);
          job_tick();
          check("gap_quiet", obs(), 0);
        end
      end
    end

    budget = 0;
    forever begin
      noise(50);
      check("drain_flags", {busy, done, src_ready}, 3'b100);
      exit_now = (exp_out == N) && drained;
      job_tick();
      check("drain_quiet", obs(), 0);
      if (exit_now) break;
      budget++;
      if (budget > 300) begin
        check("drain_timeout", {busy, done}, 2'b01);
        return;
      end
    end

    check("done_flags", {busy, done, src_ready}, 3'b110);
`ifdef SA_SEQ_PERF_CNT_EN
    check("stall_cnt", stall_cnt, 32'(exp_stall));
`endif
    noise(0);
    start = 1'($urandom);
    tick();
    check("post_done_flags", {busy, done, src_ready}, 0);
    check("post_done_quiet", obs(), 0);
    start = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  initial begin
    RST = 1'b1;
    noise(0);
    repeat (2) tick();
    check("reset_flags", {busy, done, src_ready}, 0);
    check("reset_quiet", obs(), 0);
`ifdef SA_SEQ_PERF_CNT_EN
    check("reset_stall_cnt", stall_cnt, 0);
`endif
    RST = 1'b0;
    start = 1'b0;

    run_job(1'b1, DLY_W'(1), 0, 0, 1'b0);   // weights then inputs spaced 2 cycles
    run_job(1'b0, DLY_W'(0), 0, 5, 1'b0);   // blocked 5 cycles, then back-to-back
    run_job(1'b0, DLY_W'(2), -3, 1, 1'b0);  // 3-cycle source stall before every row
    run_job(1'b1, DLY_W'(3), 1, 0, 1'b1);   // reset during GAP
    run_job(1'b0, DLY_W'(0), 0, 0, 1'b0);   // new job straight after reset
    for (int j = 0; j < 40; j++)
      run_job(1'($urandom), DLY_W'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
              int'($urandom_range(0, 4)), 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/systolic_array_row_sequencer.md
SYSTOLIC_ARRAY_ROW_SEQUENCER -- requirements
Module: systolic_array_row_sequencer

Interface
REQ-001 The block SHALL have parameter N, default 4, meaning array dimension (rows per matrix).
REQ-002 The block SHALL have parameter DW, default 16, meaning element width (fp16).
REQ-003 The block SHALL have parameter DLY_W, default 4, meaning width of the inter-row gap count.
REQ-004 The block SHALL have port clk  in  1  clock; the block SHALL use one clock only.
REQ-005 The block SHALL have port RST  in  1  reset; reset is synchronous and active-high.
REQ-006 The block SHALL have port start  in  1  job start pulse; ignored while busy.
REQ-007 The block SHALL have port load_weights  in  1  weight phase select, sampled with start.
REQ-008 The block SHALL have port row_delay  in  DLY_W  idle cycles between input rows, sampled with start.
REQ-009 The block SHALL have port src_valid  in  1  source row valid.
REQ-010 The block SHALL have port src_ready  out  1  source row accepted when src_valid&src_ready.
REQ-011 The block SHALL have ports src_data and src_partial, each  in  N*DW: row payload and partial-sum row.
REQ-012 The block SHALL have ports weight_en, input_en and partial_en, each  out  1: array load strobes.
REQ-013 The block SHALL have ports row_in_en and row_ps_en, each  out  $clog2(N): target row.
REQ-014 The block SHALL have ports array_in and array_in_partials, each  out  N*DW: row data to array.
REQ-015 The block SHALL have ports fifo_has_space, drained and out_en, each  in  1: array status and output-row strobe.
REQ-016 The block SHALL have ports busy and done, each  out  1: job active, and one-cycle completion pulse.

Function
REQ-017 The FSM SHALL have states IDLE, WLOAD, WAIT_SPACE, ILOAD, GAP, DRAIN and DONE.
REQ-018 On start in IDLE, the FSM SHALL go to WLOAD if load_weights=1, else to WAIT_SPACE.
REQ-019 src_ready SHALL be 1 only in WLOAD and ILOAD.
REQ-020 A row accepted at edge k SHALL drive the array outputs during cycle k+1 only, with strobes, row indices and data all zero otherwise.
REQ-021 In WLOAD, accepted row r SHALL drive weight_en=1, row_in_en=r, row_ps_en=0, array_in=src_data and array_in_partials=0.
REQ-022 After N weight rows, the FSM SHALL go to WAIT_SPACE.
REQ-023 In WAIT_SPACE, the FSM SHALL move to ILOAD on the first cycle with fifo_has_space=1.
REQ-024 In ILOAD, accepted row r SHALL drive input_en=partial_en=1, row_in_en=row_ps_en=r, array_in=src_data and array_in_partials=src_partial.
REQ-025 After each input row except the last, the FSM SHALL go to GAP for exactly row_delay cycles if row_delay>0; with row_delay=0, rows SHALL be accepted back-to-back.
REQ-026 After N input rows, the FSM SHALL go to DRAIN.
REQ-027 src_valid=0 SHALL stall WLOAD and ILOAD indefinitely, with no strobes emitted.
REQ-028 out_en pulses SHALL be counted from job start in any state, saturating at N.
REQ-029 DRAIN SHALL exit to DONE when the out_en count equals N and drained=1 in the same cycle.
REQ-030 DONE SHALL assert done for one cycle and then go to IDLE.
REQ-031 busy SHALL be 1 in every state except IDLE.
REQ-032 start asserted in DONE SHALL be ignored.

Reset
REQ-033 While RST=1, state SHALL be IDLE, every counter and sampled register SHALL be 0, and every output SHALL be 0.
REQ-034 RST asserted mid-job SHALL abort the job on that edge, with no further strobes.
REQ-035 A new start SHALL be accepted on the first cycle after RST deasserts.

Configuration
REQ-036 With macro SA_SEQ_PERF_CNT_EN defined, the block SHALL add output stall_cnt (16 bits), which counts WAIT_SPACE cycles plus WLOAD/ILOAD cycles with src_valid=0, is cleared on accepted start and on reset, and saturates at 16'hFFFF.
REQ-037 With SA_SEQ_PERF_CNT_EN undefined, the stall_cnt port and its logic SHALL be absent, with behaviour otherwise identical.

Structure
REQ-038 The shared package systolic_array_pkg SHALL hold N, DW and the sequencer state enum typedef.
REQ-039 The block SHALL be a single module with no sub-module; counters SHALL be inline.

Verification
REQ-040 load_weights=1, row_delay=1, src always valid: 4 weight strobes on consecutive cycles with rows 0..3, then input strobes with rows 0..3 spaced 2 cycles apart.
REQ-041 load_weights=0, row_delay=0, fifo_has_space low for 5 cycles: no strobes for 5 cycles, then 4 back-to-back input strobes.
REQ-042 src_valid deasserted for 3 cycles mid-ILOAD: strobes pause 3 cycles, row order is preserved, and stall_cnt (if enabled) increases by 3.
REQ-043 4 out_en pulses with drained rising 2 cycles after the last pulse: done pulses 1 cycle after drained=1, then busy=0.
REQ-044 RST asserted during GAP: all outputs 0 the next cycle, state IDLE, and a following job runs correctly from row 0.
REQ-045 start pulsed while busy: ignored, and the job count and sampled row_delay are unchanged.
